mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
Sits directly downstream of the mp3 CPU's split instruction and data memory ports. It merges them onto a single physical memory port by serving one word transaction at a time. Each side gets its own response pulse and read data, so the CPU can stall each pipeline stage independently. A saturating conflict counter exposes contention for performance debug.

Parameters:
DATA_W, 16, data word width (lc3b_word)
ADDR_W, 16, address width
MASK_W, 2, byte-enable width (lc3b_mem_wmask)
FAIRNESS, 1, 1 = round-robin on simultaneous requests; 0 = data side always wins
CNT_W, 16, width of conflict_count

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
inst_mem_read  in  1  instruction-side read request, level, held until inst_mem_resp
inst_mem_write  in  1  instruction-side write request, level
inst_mem_byte_enable  in  MASK_W  instruction-side write byte mask
inst_mem_addr  in  ADDR_W  instruction-side address
inst_mem_wdata  in  DATA_W  instruction-side write data
inst_mem_resp  out  1  one-cycle completion pulse to instruction side
inst_mem_rdata  out  DATA_W  instruction-side read data, valid while inst_mem_resp=1
data_mem_read / data_mem_write / data_mem_byte_enable / data_mem_addr / data_mem_wdata  in  1/1/MASK_W/ADDR_W/DATA_W  data-side request, same rules as instruction side
data_mem_resp  out  1  one-cycle completion pulse to data side
data_mem_rdata  out  DATA_W  data-side read data, valid while data_mem_resp=1
pmem_read  out  1  physical memory read strobe
pmem_write  out  1  physical memory write strobe
pmem_byte_enable  out  MASK_W  physical write mask
pmem_addr  out  ADDR_W  physical address
pmem_wdata  out  DATA_W  physical write data
pmem_resp  in  1  physical memory completion, one cycle
pmem_rdata  in  DATA_W  physical read data, valid with pmem_resp
conflict_count  out  CNT_W  number of IDLE cycles in which both sides requested, saturating

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; every pmem_* output = 0; both *_resp = 0; both *_rdata = 0.
  - last_grant = INST, so data wins the first conflict; conflict_count = 0.
- FSM states: IDLE, BUSY, RESP.
- IDLE:
  - A side "requests" when its read|write = 1.
  - No request: stay in IDLE.
  - One side requesting: grant that side.
  - Both requesting: increment conflict_count (saturate at all-ones).
    - FAIRNESS=1: grant the side opposite last_grant.
    - FAIRNESS=0: grant data.
  - On grant: latch op, addr, wdata and mask into registers; set last_grant; go to BUSY next cycle.
- Illegal request (read=write=1 on one side): served as a write.
- BUSY:
  - pmem_read/pmem_write, pmem_addr, pmem_wdata and pmem_byte_enable are driven only from the latched registers, never combinationally from CPU inputs.
  - Strobes are held until pmem_resp.
  - On pmem_resp=1: capture pmem_rdata (reads only; writes return 0); deassert the strobe next cycle; go to RESP.
- RESP:
  - Pulse the granted side's *_resp for exactly one cycle, with its *_rdata driven from the capture register.
  - The other side's resp stays 0 and its rdata stays 0.
  - Next state is IDLE.
- Requester contract: the CPU drops or changes its request the cycle after its resp. IDLE then re-samples, so no request is served twice.
- Latency:
  - Grant cycle to pmem strobe: 1 cycle (strobe asserts in the first BUSY cycle).
  - pmem_resp to side resp: 1 cycle.
  - Uncontended minimum: request seen in IDLE at cycle 0, strobe at cycle 1, pmem_resp at cycle 1 gives side resp at cycle 2.
- Non-granted requester: waits, with no timeout. A new request arriving during BUSY/RESP is considered only on return to IDLE.
- Request changes while granted: addr/wdata changes after the grant are ignored (latched copy is used).
- pmem_resp outside BUSY: ignored.
- Reset mid-transaction: strobes drop immediately (async), state returns to IDLE, no resp is issued. The physical memory must tolerate the abort.

Test Plan:
- Reset then idle: rst_n low mid-cycle → all pmem_*, resps and rdata are 0 asynchronously; conflict_count=0.
- Lone inst read: addr 0x0010, pmem returns 0x1234 after 3 cycles → pmem_addr=0x0010, pmem_read high for 3 cycles, then inst_mem_resp one cycle with inst_mem_rdata=0x1234; data_mem_resp stays 0.
- Lone data write: addr 0x2002, wdata 0xBEEF, mask 2'b10 → pmem_write with exactly these values; data_mem_resp pulses once; data_mem_rdata=0.
- Simultaneous requests, FAIRNESS=1, both held for 3 back-to-back rounds → grant order data, inst, data; conflict_count increments once per contended IDLE sample.
- FAIRNESS=0, both held → data always served first; inst served only after data deasserts.
- Reset during BUSY with pmem_read=1 → pmem_read drops without waiting for clk; after release, the same held request is re-served cleanly with a single resp.

Source files
------------

// File: rtl/mem_arbiter.sv
// Merges the split instruction/data memory ports onto one physical memory port,
// serving one word transaction at a time with per-side response pulses.
module mem_arbiter #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 16,
  parameter int MASK_W   = 2,
  parameter int FAIRNESS = 1,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic              inst_mem_read,
  input  logic              inst_mem_write,
  input  logic [MASK_W-1:0] inst_mem_byte_enable,
  input  logic [ADDR_W-1:0] inst_mem_addr,
  input  logic [DATA_W-1:0] inst_mem_wdata,
  output logic              inst_mem_resp,
  output logic [DATA_W-1:0] inst_mem_rdata,

  input  logic              data_mem_read,
  input  logic              data_mem_write,
  input  logic [MASK_W-1:0] data_mem_byte_enable,
  input  logic [ADDR_W-1:0] data_mem_addr,
  input  logic [DATA_W-1:0] data_mem_wdata,
  output logic              data_mem_resp,
  output logic [DATA_W-1:0] data_mem_rdata,

  output logic              pmem_read,
  output logic              pmem_write,
  output logic [MASK_W-1:0] pmem_byte_enable,
  output logic [ADDR_W-1:0] pmem_addr,
  output logic [DATA_W-1:0] pmem_wdata,
  input  logic              pmem_resp,
  input  logic [DATA_W-1:0] pmem_rdata,

  output logic [CNT_W-1:0]  conflict_count
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;
  typedef enum logic {SIDE_INST = 1'b0, SIDE_DATA = 1'b1} side_e;

  state_e state_q, state_d;
  side_e  grant_q, last_grant_q, grant_d;
  logic   take_grant;

  logic              op_read_q, op_write_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [MASK_W-1:0] mask_q;
  logic [DATA_W-1:0] rdata_q;
  logic [CNT_W-1:0]  conflict_count_q;

  logic inst_req, data_req, both_req;
  logic sel_read, sel_write;

  assign inst_req = inst_mem_read | inst_mem_write;
  assign data_req = data_mem_read | data_mem_write;
  assign both_req = inst_req & data_req;

  // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    state_d    = state_q;
    grant_d    = SIDE_DATA;
    take_grant = 1'b0;
    case (state_q)
      IDLE: begin
        if (inst_req || data_req) begin
          take_grant = 1'b1;
          state_d    = BUSY;
          if (both_req)
            grant_d = (FAIRNESS != 0 && last_grant_q == SIDE_DATA) ? SIDE_INST : SIDE_DATA;
          else
            grant_d = data_req ? SIDE_DATA : SIDE_INST;
        end
      end
      BUSY:    if (pmem_resp) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign sel_read  = (grant_d == SIDE_DATA) ? data_mem_read  : inst_mem_read;
  assign sel_write = (grant_d == SIDE_DATA) ? data_mem_write : inst_mem_write;

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_q          <= SIDE_INST;
      last_grant_q     <= SIDE_INST;
      op_read_q        <= 1'b0;
      op_write_q       <= 1'b0;
      addr_q           <= '0;
      wdata_q          <= '0;
      mask_q           <= '0;
      rdata_q          <= '0;
      conflict_count_q <= '0;
    end else begin
      if (take_grant) begin
        grant_q      <= grant_d;
        last_grant_q <= grant_d;
        // A side asserting read and write together is served as a write.
        op_write_q   <= sel_write;
        op_read_q    <= sel_read & ~sel_write;
        addr_q       <= (grant_d == SIDE_DATA) ? data_mem_addr        : inst_mem_addr;
        wdata_q      <= (grant_d == SIDE_DATA) ? data_mem_wdata       : inst_mem_wdata;
        mask_q       <= (grant_d == SIDE_DATA) ? data_mem_byte_enable : inst_mem_byte_enable;
      end
      if (state_q == BUSY && pmem_resp)
        rdata_q <= op_read_q ? pmem_rdata : '0;
      if (state_q == IDLE && both_req && conflict_count_q != '1)
        conflict_count_q <= conflict_count_q + CNT_W'(1);
    end
  end

  // Physical port only ever sees the latched copy, and only while BUSY.
  logic busy, resp_cycle;
  assign busy       = (state_q == BUSY);
  assign resp_cycle = (state_q == RESP);

  assign pmem_read        = busy & op_read_q;
  assign pmem_write       = busy & op_write_q;
  assign pmem_addr        = busy ? addr_q  : '0;
  assign pmem_wdata       = busy ? wdata_q : '0;
  assign pmem_byte_enable = busy ? mask_q  : '0;

  assign inst_mem_resp  = resp_cycle & (grant_q == SIDE_INST);
  assign data_mem_resp  = resp_cycle & (grant_q == SIDE_DATA);
  assign inst_mem_rdata = inst_mem_resp ? rdata_q : '0;
  assign data_mem_rdata = data_mem_resp ? rdata_q : '0;

  assign conflict_count = conflict_count_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a round-robin instance and a data-priority instance
// share the CPU-side stimulus; each has its own small physical-memory responder.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        inst_read, inst_write, data_read, data_write;
  logic [1:0]  inst_be, data_be;
  logic [15:0] inst_addr, inst_wdata, data_addr, data_wdata;

  logic        pa_read, pa_write, pa_resp;
  logic [1:0]  pa_be;
  logic [15:0] pa_addr, pa_wdata, pa_rdata;
  logic        a_inst_resp, a_data_resp;
  logic [15:0] a_inst_rdata, a_data_rdata, a_cc;

  logic        pb_read, pb_write, pb_resp;
  logic [1:0]  pb_be;
  logic [15:0] pb_addr, pb_wdata, pb_rdata;
  logic        b_inst_resp, b_data_resp;
  logic [15:0] b_inst_rdata, b_data_rdata, b_cc;

  int          lat_v = 1;
  logic [15:0] rd_value = 16'h0000;
  int          cnt_a, cnt_b;
  int          n_checks = 0;
  int          n_errors = 0;

  mem_arbiter #(.FAIRNESS(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .inst_mem_read(inst_read), .inst_mem_write(inst_write), .inst_mem_byte_enable(inst_be),
    .inst_mem_addr(inst_addr), .inst_mem_wdata(inst_wdata),
    .inst_mem_resp(a_inst_resp), .inst_mem_rdata(a_inst_rdata),
    .data_mem_read(data_read), .data_mem_write(data_write), .data_mem_byte_enable(data_be),
    .data_mem_addr(data_addr), .data_mem_wdata(data_wdata),
    .data_mem_resp(a_data_resp), .data_mem_rdata(a_data_rdata),
    .pmem_read(pa_read), .pmem_write(pa_write), .pmem_byte_enable(pa_be),
    .pmem_addr(pa_addr), .pmem_wdata(pa_wdata), .pmem_resp(pa_resp), .pmem_rdata(pa_rdata),
    .conflict_count(a_cc)
  );

  mem_arbiter #(.FAIRNESS(0)) dut_nf (
    .clk(clk), .rst_n(rst_n),
    .inst_mem_read(inst_read), .inst_mem_write(inst_write), .inst_mem_byte_enable(inst_be),
    .inst_mem_addr(inst_addr), .inst_mem_wdata(inst_wdata),
    .inst_mem_resp(b_inst_resp), .inst_mem_rdata(b_inst_rdata),
    .data_mem_read(data_read), .data_mem_write(data_write), .data_mem_byte_enable(data_be),
    .data_mem_addr(data_addr), .data_mem_wdata(data_wdata),
    .data_mem_resp(b_data_resp), .data_mem_rdata(b_data_rdata),
    .pmem_read(pb_read), .pmem_write(pb_write), .pmem_byte_enable(pb_be),
    .pmem_addr(pb_addr), .pmem_wdata(pb_wdata), .pmem_resp(pb_resp), .pmem_rdata(pb_rdata),
    .conflict_count(b_cc)
  );

  // Physical memory: completes after lat_v strobe cycles; rdata is junk outside resp.
  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_a = 0; pa_resp = 1'b0;
    end else if (pa_read || pa_write) begin
      if (cnt_a == lat_v - 1) begin pa_resp = 1'b1; cnt_a = 0; end
      else begin pa_resp = 1'b0; cnt_a++; end
    end else begin
      pa_resp = 1'b0; cnt_a = 0;
    end
  end

  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_b = 0; pb_resp = 1'b0;
    end else if (pb_read || pb_write) begin
      if (cnt_b == lat_v - 1) begin pb_resp = 1'b1; cnt_b = 0; end
      else begin pb_resp = 1'b0; cnt_b++; end
    end else begin
      pb_resp = 1'b0; cnt_b = 0;
    end
  end

  assign pa_rdata = pa_resp ? rd_value : 16'hDEAD;
  assign pb_rdata = pb_resp ? rd_value : 16'hDEAD;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic drop_all();
    inst_read = 0; inst_write = 0; inst_be = 0; inst_addr = 0; inst_wdata = 0;
    data_read = 0; data_write = 0; data_be = 0; data_addr = 0; data_wdata = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Waits (bounded) for a resp pulse from the chosen instance.
  task automatic wait_resp(input bit on_b, output bit got, output bit is_data,
                           output logic [15:0] rdata);
    got = 0; is_data = 0; rdata = '0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (!on_b && (a_inst_resp || a_data_resp)) begin
        got = 1; is_data = a_data_resp; rdata = a_data_resp ? a_data_rdata : a_inst_rdata;
        break;
      end
      if (on_b && (b_inst_resp || b_data_resp)) begin
        got = 1; is_data = b_data_resp; rdata = b_data_resp ? b_data_rdata : b_inst_rdata;
        break;
      end
    end
  endtask

  typedef struct {
    logic ir, iw; logic [1:0] im; logic [15:0] ia, iwd;
    logic dr, dw; logic [1:0] dm; logic [15:0] da, dwd;
    int lat; logic [15:0] rdv;
    logic exp_data; logic exp_rd, exp_wr;
    logic [15:0] exp_addr, exp_wdata; logic [1:0] exp_mask; logic [15:0] exp_rdata;
    int exp_cc;
  } vec_t;

  vec_t vecs[7];

  task automatic run_vec(input vec_t v, input int idx);
    int first_strobe, strobe_cycles, resp_idx;
    bit got, side_data, other_resp;
    logic [15:0] rdata, other_rdata;
    first_strobe = -1; strobe_cycles = 0; resp_idx = -1;
    got = 0; side_data = 0; other_resp = 0; rdata = '0; other_rdata = '0;
    inst_read = v.ir; inst_write = v.iw; inst_be = v.im; inst_addr = v.ia; inst_wdata = v.iwd;
    data_read = v.dr; data_write = v.dw; data_be = v.dm; data_addr = v.da; data_wdata = v.dwd;
    lat_v = v.lat; rd_value = v.rdv;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (pa_read || pa_write) begin
        if (first_strobe < 0) first_strobe = c;
        strobe_cycles++;
        check($sformatf("v%0d_pmem_read", idx),  pa_read,  v.exp_rd);
        check($sformatf("v%0d_pmem_write", idx), pa_write, v.exp_wr);
        check($sformatf("v%0d_pmem_addr", idx),  pa_addr,  v.exp_addr);
        check($sformatf("v%0d_pmem_wdata", idx), pa_wdata, v.exp_wdata);
        check($sformatf("v%0d_pmem_mask", idx),  pa_be,    v.exp_mask);
        // Scramble the held request payload; the latched copy must stay on the bus.
        inst_addr = ~inst_addr; inst_wdata = ~inst_wdata; inst_be = ~inst_be;
        data_addr = ~data_addr; data_wdata = ~data_wdata; data_be = ~data_be;
      end
      if (a_inst_resp || a_data_resp) begin
        got = 1; resp_idx = c; side_data = a_data_resp;
        rdata       = a_data_resp ? a_data_rdata : a_inst_rdata;
        other_resp  = a_data_resp ? a_inst_resp  : a_data_resp;
        other_rdata = a_data_resp ? a_inst_rdata : a_data_rdata;
        break;
      end
    end
    drop_all();
    check($sformatf("v%0d_resp_seen", idx),     got,           1);
    check($sformatf("v%0d_strobe_start", idx),  first_strobe,  0);
    check($sformatf("v%0d_strobe_cycles", idx), strobe_cycles, v.lat);
    check($sformatf("v%0d_resp_latency", idx),  resp_idx,      v.lat);
    check($sformatf("v%0d_resp_side", idx),     side_data,     v.exp_data);
    check($sformatf("v%0d_rdata", idx),         rdata,         v.exp_rdata);
    check($sformatf("v%0d_other_resp", idx),    other_resp,    0);
    check($sformatf("v%0d_other_rdata", idx),   other_rdata,   0);
    @(posedge clk); #1;
    check($sformatf("v%0d_single_pulse", idx), {a_inst_resp, a_data_resp}, 2'b00);
    check($sformatf("v%0d_conflicts", idx),    a_cc, v.exp_cc);
  endtask

  initial begin
    bit got, is_data;
    logic [15:0] rdata;
    int n_resp;
    bit seen;

    //            ir iw im     ia        iwd       dr dw dm     da        dwd       lat rdv       data rd wr addr      wdata     mask   rdata     cc
    vecs[0] = '{1'b1,1'b0,2'b00,16'h0010,16'h0000,1'b0,1'b0,2'b00,16'h0000,16'h0000,3,16'h1234,1'b0,1'b1,1'b0,16'h0010,16'h0000,2'b00,16'h1234,0};
    vecs[1] = '{1'b0,1'b0,2'b00,16'h0000,16'h0000,1'b0,1'b1,2'b10,16'h2002,16'hBEEF,1,16'h5555,1'b1,1'b0,1'b1,16'h2002,16'hBEEF,2'b10,16'h0000,0};
    vecs[2] = '{1'b1,1'b0,2'b00,16'h0100,16'h0000,1'b1,1'b0,2'b00,16'h0200,16'h0000,2,16'h0F0F,1'b0,1'b1,1'b0,16'h0100,16'h0000,2'b00,16'h0F0F,1};
    vecs[3] = '{1'b0,1'b1,2'b01,16'h0300,16'h1111,1'b0,1'b1,2'b11,16'h0400,16'h2222,1,16'hAAAA,1'b1,1'b0,1'b1,16'h0400,16'h2222,2'b11,16'h0000,2};
    vecs[4] = '{1'b0,1'b0,2'b00,16'h0000,16'h0000,1'b1,1'b1,2'b11,16'h0500,16'h3333,2,16'h7777,1'b1,1'b0,1'b1,16'h0500,16'h3333,2'b11,16'h0000,2};
    vecs[5] = '{1'b1,1'b0,2'b00,16'hFFFF,16'h0000,1'b0,1'b0,2'b00,16'h0000,16'h0000,1,16'hFFFF,1'b0,1'b1,1'b0,16'hFFFF,16'h0000,2'b00,16'hFFFF,2};
    vecs[6] = '{1'b0,1'b0,2'b00,16'h0000,16'h0000,1'b1,1'b0,2'b00,16'h0000,16'h0000,4,16'h8001,1'b1,1'b1,1'b0,16'h0000,16'h0000,2'b00,16'h8001,2};

    drop_all();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_pmem", {pa_read, pa_write, pa_be, pa_addr, pa_wdata}, 36'h0);
    check("reset_resp", {a_inst_resp, a_data_resp, a_inst_rdata, a_data_rdata}, 34'h0);
    check("reset_cc", a_cc, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

    // Async reset while BUSY, then the held request is re-served exactly once.
    inst_read = 1; inst_addr = 16'h0040; lat_v = 8; rd_value = 16'h4444;
    seen = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (pa_read) begin seen = 1; break; end
    end
    check("abort_strobe_seen", seen, 1);
    #2 rst_n = 1'b0;
    #1;
    check("abort_pmem_async", {pa_read, pa_write, pa_be, pa_addr, pa_wdata}, 36'h0);
    check("abort_cc_async", a_cc, 0);
    @(posedge clk); #1;
    check("abort_no_resp", {a_inst_resp, a_data_resp, a_inst_rdata, a_data_rdata}, 34'h0);
    @(negedge clk);
    rst_n = 1'b1;
    n_resp = 0; rdata = '0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (a_data_resp) n_resp += 10;
      if (a_inst_resp) begin
        n_resp++; rdata = a_inst_rdata;
        drop_all();
      end
    end
    check("reserve_resp_count", n_resp, 1);
    check("reserve_rdata", rdata, 16'h4444);

    // Round-robin: both held for three rounds.
    do_reset();
    lat_v = 1; rd_value = 16'hC0DE;
    inst_read = 1; inst_addr = 16'h1000; data_read = 1; data_addr = 16'h2000;
    for (int r = 0; r < 3; r++) begin
      wait_resp(1'b0, got, is_data, rdata);
      check($sformatf("rr%0d_resp_seen", r), got, 1);
      check($sformatf("rr%0d_side", r), is_data, (r != 1));
      check($sformatf("rr%0d_rdata", r), rdata, 16'hC0DE);
      check($sformatf("rr%0d_cc", r), a_cc, r + 1);
    end
    drop_all();

    // Data priority: data wins while held; inst only after data drops.
    do_reset();
    lat_v = 2; rd_value = 16'h5A5A;
    inst_read = 1; inst_addr = 16'h3000; data_read = 1; data_addr = 16'h4000;
    for (int r = 0; r < 3; r++) begin
      wait_resp(1'b1, got, is_data, rdata);
      check($sformatf("nf%0d_resp_seen", r), got, 1);
      check($sformatf("nf%0d_side", r), is_data, (r != 2));
      if (r == 1) begin data_read = 0; data_addr = 0; end
    end
    drop_all();
    check("nf_cc", b_cc, 2);
    repeat (2) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
